// File: rtl/ir_tx_framer.sv
// IR UART-style transmitter: start/data/[parity]/stop framing with carrier-modulated marks.
// Optional even-parity bit enabled by defining IR_TX_PARITY_EN.
module ir_tx_framer #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned CARRIER_HZ = 38_000,
  parameter int unsigned BAUD       = 2_400,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic              CLK_50M,
  input  logic              reset,
  input  logic              send_en,
  input  logic [DATA_W-1:0] Din,
  output logic              IRDA_TXD,
  output logic              busy,
  output logic              done
);

  localparam int unsigned HALF       = CLK_HZ / (2 * CARRIER_HZ);
  localparam int unsigned BIT_CYCLES = CLK_HZ / BAUD;
  localparam int unsigned TMR_W      = $clog2(BIT_CYCLES) + 1;
  localparam int unsigned CAR_W      = $clog2(2 * HALF) + 1;
  localparam int unsigned CNT_W      = $clog2(DATA_W) + 1;

  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(BIT_CYCLES - 1);
  localparam logic [CAR_W-1:0] CAR_LAST  = CAR_W'(2 * HALF - 1);
  localparam logic [CAR_W-1:0] CAR_HALF  = CAR_W'(HALF);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

  if (HALF < 1) begin : g_chk_half
    $error("ir_tx_framer: carrier half-period below one clock");
  end
  if (BIT_CYCLES < 2 * HALF) begin : g_chk_bit
    $error("ir_tx_framer: bit period shorter than one carrier period");
  end
  if (DATA_W < 1 || DATA_W > 16) begin : g_chk_dw
    $error("ir_tx_framer: DATA_W must be 1..16");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("ir_tx_framer: STOP_BITS must be 1..2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef IR_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t              r_state, w_state_n;
  logic [TMR_W-1:0]    r_tmr, w_tmr_n;
  logic [CAR_W-1:0]    r_car, w_car_n;
  logic [CNT_W-1:0]    r_cnt, w_cnt_n;
  logic [DATA_W-1:0]   r_shift, w_shift_n;
  logic                r_txd, w_txd_n;
  logic                r_busy, w_busy_n;
  logic                r_done, w_done_n;
  logic                w_bit_end;
  logic                w_mark_n;
`ifdef IR_TX_PARITY_EN
  logic                r_par, w_par_n;
`endif

  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_car   <= '0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef IR_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      r_tmr   <= w_tmr_n;
      r_car   <= w_car_n;
      r_cnt   <= w_cnt_n;
      r_shift <= w_shift_n;
      r_txd   <= w_txd_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
`ifdef IR_TX_PARITY_EN
      r_par   <= w_par_n;
`endif
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_tmr_n   = r_tmr;
    w_cnt_n   = r_cnt;
    w_shift_n = r_shift;
    w_done_n  = 1'b0;
    w_car_n   = (r_car == CAR_LAST) ? '0 : r_car + 1'b1;
    w_bit_end = (r_tmr == TMR_LAST);
    w_mark_n  = 1'b0;
`ifdef IR_TX_PARITY_EN
    w_par_n   = r_par;
`endif

    if (r_state == S_IDLE) begin
      w_tmr_n = '0;
      w_car_n = '0;
    end else begin
      w_tmr_n = w_bit_end ? '0 : r_tmr + 1'b1;
    end

    unique case (r_state)
      S_IDLE: begin
        if (send_en) begin
          w_state_n = S_START;
          w_shift_n = Din;
          w_cnt_n   = '0;
`ifdef IR_TX_PARITY_EN
          w_par_n   = ^Din;
`endif
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_n = S_DATA;
          w_cnt_n   = '0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_n = r_shift >> 1;
          if (r_cnt == DATA_LAST) begin
            w_cnt_n   = '0;
`ifdef IR_TX_PARITY_EN
            w_state_n = S_PARITY;
`else
            w_state_n = S_STOP;
`endif
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
      end
`ifdef IR_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_n = S_STOP;
          w_cnt_n   = '0;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          if (r_cnt == STOP_LAST) begin
            w_state_n = S_IDLE;
            w_cnt_n   = '0;
            w_done_n  = 1'b1;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    // Output register is loaded from next-cycle values so the LED tracks the state it belongs to.
    unique case (w_state_n)
      S_START:  w_mark_n = 1'b1;
      S_DATA:   w_mark_n = ~w_shift_n[0];
`ifdef IR_TX_PARITY_EN
      S_PARITY: w_mark_n = ~w_par_n;
`endif
      default:  w_mark_n = 1'b0;
    endcase

    w_txd_n  = w_mark_n & (w_car_n < CAR_HALF);
    w_busy_n = (w_state_n != S_IDLE);
  end

  assign IRDA_TXD = r_txd;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_ir_tx_framer.sv
// Scoreboard bench for ir_tx_framer: stimulus queues expected frames, a negedge monitor checks them.
module tb_ir_tx_framer;

  localparam int BITC = 20;
  localparam int HALFC = 5;
`ifdef IR_TX_PARITY_EN
  localparam int NBITS = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int NBITS = 10;
  localparam bit PAR = 1'b0;
`endif
  localparam int FLEN = NBITS * BITC;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       send_en = 1'b0;
  logic [7:0] din = '0;
  logic       txd, busy, done;

  ir_tx_framer #(
    .CLK_HZ(1000), .CARRIER_HZ(100), .BAUD(50), .DATA_W(8), .STOP_BITS(1)
  ) dut (
    .CLK_50M(clk), .reset(reset), .send_en(send_en), .Din(din),
    .IRDA_TXD(txd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] mask;   // hand-computed mark map per bit index (bit 9 = parity mark)
    int          len;
    bit          done_exp;
    int          gap;    // expected idle samples before frame, -1 = don't care
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int idle_err = 0;

  function automatic void check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  // Monitor / scoreboard
  exp_t cur;
  bit   have = 1'b0;
  bit   prev_busy = 1'b0;
  int   k = 0;
  int   errs = 0;
  int   first_k = 0;
  int   gap_cnt = 0;

  function automatic logic exp_txd(input logic [10:0] m, input int kk);
    int  b;
    logic mk;
    b = kk / BITC;
    if (b <= 8) mk = m[b];
    else if (b == 9 && PAR) mk = m[9];
    else mk = 1'b0;
    return mk & ((kk % (2 * HALFC)) < HALFC);
  endfunction

  always @(negedge clk) begin
    if (busy) begin
      if (!prev_busy) begin
        k = 0;
        errs = 0;
        if (q.size() == 0) begin
          check("unexpected_frame", 1, 0);
          have = 1'b0;
        end else begin
          cur = q.pop_front();
          have = 1'b1;
          if (cur.gap >= 0) check("idle_gap", gap_cnt, cur.gap);
        end
      end
      if (have && txd !== exp_txd(cur.mask, k)) begin
        if (errs == 0) first_k = k;
        errs++;
      end
      if (done) idle_err++;
      k++;
    end else begin
      if (prev_busy) begin
        if (have) begin
          check("frame_len", k, cur.len);
          check("done_at_end", int'(done), int'(cur.done_exp));
          if (errs != 0) $display("FAIL txd_wave first bad cycle %0d", first_k);
          check("txd_wave_errs", errs, 0);
        end
        have = 1'b0;
        gap_cnt = 1;
      end else begin
        gap_cnt++;
        if (done) idle_err++;
      end
      if (txd !== 1'b0) idle_err++;
    end
    prev_busy = busy;
  end

  task automatic send(input logic [7:0] d, input logic [10:0] m, input int len,
                      input bit dn, input int gap);
    exp_t e;
    e.mask = m; e.len = len; e.done_exp = dn; e.gap = gap;
    q.push_back(e);
    din = d;
    send_en = 1'b1;
    @(posedge clk); #1;
    send_en = 1'b0;
    din = ~d;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!busy && q.size() == 0) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("wait_idle_timeout", int'(ok), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset with send_en held
    @(posedge clk); #1;
    reset = 1'b1; send_en = 1'b1; din = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_txd", int'(txd), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
    end
    @(posedge clk); #1;
    reset = 1'b0; send_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 2/3: basic frames
    send(8'hA5, 11'h2B5, FLEN, 1'b1, -1);
    wait_idle();
    send(8'h00, 11'h3FF, FLEN, 1'b1, -1);
    wait_idle();

    // 4: send_en during a frame is ignored
    send(8'hA5, 11'h2B5, FLEN, 1'b1, -1);
    repeat (49) @(posedge clk);
    #1;
    din = 8'hFF; send_en = 1'b1;
    @(posedge clk); #1;
    send_en = 1'b0;
    wait_idle();

    // 5: reset aborts a frame at clk 30
    send(8'hA5, 11'h2B5, 30, 1'b0, -1);
    repeat (29) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    wait_idle();
    send(8'h3C, 11'h387, FLEN, 1'b1, -1);
    wait_idle();

    // 6: back-to-back via send_en in the done cycle
    send(8'hFF, 11'h201, FLEN, 1'b1, -1);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
        @(posedge clk); #1;
        if (done) begin seen = 1'b1; break; end
      end
      check("done_seen_timeout", int'(seen), 1);
      if (seen) send(8'h3C, 11'h387, FLEN, 1'b1, 1);
    end
    wait_idle();

    check("queue_empty", q.size(), 0);
    check("idle_violations", idle_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
